// File: rtl/memory_port_arbiter_if.sv
// Bus bundle between memory_port_arbiter, its two requesters and the Memory.
// The arbiter binds the slave modport; requesters and the memory model use master.
interface memory_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Handshake: a requester raises *_req with we/address/wdata valid and holds req
    // until it sees the one-cycle *_ack; read data is valid only while *_ack is high.
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_address;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_ack;
    logic [DATA_WIDTH-1:0] core_rdata;

    logic                  loader_req;
    logic                  loader_we;
    logic [ADDR_WIDTH-1:0] loader_address;
    logic [DATA_WIDTH-1:0] loader_wdata;
    logic                  loader_ack;
    logic [DATA_WIDTH-1:0] loader_rdata;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic                  owner;
    logic [1:0]            state;   // debug view of the FSM: 0 IDLE, 1 BUSY, 2 RESP

    modport slave (
        input  core_req, core_we, core_address, core_wdata,
        input  loader_req, loader_we, loader_address, loader_wdata,
        input  mem_rdata,
        output core_ack, core_rdata, loader_ack, loader_rdata,
        output mem_address, mem_wdata, mem_write, mem_read,
        output busy, owner, state
    );

    modport master (
        output core_req, core_we, core_address, core_wdata,
        output loader_req, loader_we, loader_address, loader_wdata,
        output mem_rdata,
        input  core_ack, core_rdata, loader_ack, loader_rdata,
        input  mem_address, mem_wdata, mem_write, mem_read,
        input  busy, owner, state
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Two-requester (core / loader) arbiter for the single Memory port, fixed-latency FSM.
// Macro ARB_ROUND_ROBIN_EN: ties alternate owners; undefined, the core wins every tie.
module memory_port_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    memory_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_core_rdata;
    logic [DATA_WIDTH-1:0] r_loader_rdata;

    logic                  w_any_req;
    logic                  w_grant_loader;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_in_busy;
    logic                  w_in_resp;
    logic                  w_last_busy;
    logic [1:0]            w_state_nxt;

    assign w_any_req = bus.core_req | bus.loader_req;

    // Arbitration decision; only consumed in IDLE and registered on the grant edge.
    always_comb begin
        w_grant_loader = 1'b0;
        if (bus.core_req && bus.loader_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant_loader = ~r_owner;
`else
            w_grant_loader = 1'b0;
`endif
        end else begin
            w_grant_loader = bus.loader_req;
        end
    end

    always_comb begin
        w_sel_we    = bus.core_we;
        w_sel_addr  = bus.core_address;
        w_sel_wdata = bus.core_wdata;
        if (w_grant_loader) begin
            w_sel_we    = bus.loader_we;
            w_sel_addr  = bus.loader_address;
            w_sel_wdata = bus.loader_wdata;
        end
    end

    assign w_in_busy   = (r_state == BUSY);
    assign w_in_resp   = (r_state == RESP);
    assign w_last_busy = w_in_busy && (r_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner resets to loader so the first tie under alternation goes to the core.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_owner <= w_grant_loader;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_cnt <= WAIT_LOAD;
        end else if (w_in_busy && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Read data lands on the last BUSY edge so it is valid alongside the ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_core_rdata   <= '0;
            r_loader_rdata <= '0;
        end else if (w_last_busy && !r_we) begin
            if (r_owner) begin
                r_loader_rdata <= bus.mem_rdata;
            end else begin
                r_core_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_address  = w_in_busy ? r_addr  : '0;
    assign bus.mem_wdata    = w_in_busy ? r_wdata : '0;
    assign bus.mem_read     = w_in_busy & ~r_we;
    assign bus.mem_write    = w_in_busy &  r_we;

    assign bus.core_ack     = w_in_resp & ~r_owner;
    assign bus.loader_ack   = w_in_resp &  r_owner;
    assign bus.core_rdata   = r_core_rdata;
    assign bus.loader_rdata = r_loader_rdata;

    assign bus.busy         = w_in_busy | w_in_resp;
    assign bus.owner        = r_owner;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: three instances (WAIT_CYCLES 0, 3, 5) sharing one clock.
// Honours ARB_ROUND_ROBIN_EN for the arbitration expectations.
module tb_memory_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W0 = 0;

  logic clock = 1'b0;
  logic rst0, rst3, rst5;
  always #5 clock = ~clock;

  memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();
  memory_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if5 ();

  memory_port_arbiter #(.WAIT_CYCLES(W0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut0 (
    .clock(clock), .reset_n(rst0), .bus(if0.slave));
  memory_port_arbiter #(.WAIT_CYCLES(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut3 (
    .clock(clock), .reset_n(rst3), .bus(if3.slave));
  memory_port_arbiter #(.WAIT_CYCLES(5), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut5 (
    .clock(clock), .reset_n(rst5), .bus(if5.slave));

  // Small word memory behind instance 0, indexed by address[5:2]
  logic [DW-1:0] mem0 [16] = '{default: '0};
  logic          pre_en;
  logic [3:0]    pre_idx;
  logic [DW-1:0] pre_val;
  always @(posedge clock) begin
    if (if0.mem_write) mem0[if0.mem_address[5:2]] <= if0.mem_wdata;
    else if (pre_en) mem0[pre_idx] <= pre_val;
  end
  assign if0.mem_rdata = mem0[if0.mem_address[5:2]];
  assign if3.mem_rdata = 32'h0;
  assign if5.mem_rdata = 32'h1234_5678;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits on instance 0 for the wanted ack; lat stays -1 if it never comes.
  task automatic wait_ack0(input logic want_ld, input int limit, output int lat,
                           output int n_rd, output int n_wr, output int n_oth);
    lat = -1; n_rd = 0; n_wr = 0; n_oth = 0;
    for (int n = 1; n <= limit && lat < 0; n++) begin
      @(negedge clock);
      if (if0.mem_read) n_rd++;
      if (if0.mem_write) n_wr++;
      if (want_ld ? if0.core_ack : if0.loader_ack) n_oth++;
      if (want_ld ? if0.loader_ack : if0.core_ack) lat = n;
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [DW-1:0] val);
    pre_idx = idx; pre_val = val; pre_en = 1'b1;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  typedef struct {
    logic          ld;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          pre;
    logic [DW-1:0] pval;
    logic [DW-1:0] exp_crd;
    logic [DW-1:0] exp_lrd;
  } vec_t;

  vec_t vt[6];
  logic exp_own[6];
  logic [DW-1:0] mm[16];

  initial begin
    int lat, n_rd, n_wr, n_oth, bad, got, rem_c, rem_l;
    logic m_have, m_ld, m_we, m_owner, in_busy, in_resp;
    int m_gs, m_free;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd, e_crd, e_lrd;
    logic [5:0] e_ctl;
    logic [63:0] e_bus;

    vt[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,         1'b1, 32'h0050_0093, 32'h0050_0093, 32'h0};
    vt[1] = '{1'b0, 1'b1, 32'h0000_0004, 32'h1111_2222, 1'b0, 32'h0,         32'h0050_0093, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'hCAFE_F00D, 32'h0050_0093, 32'hCAFE_F00D};
    vt[3] = '{1'b1, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0, 32'h0,         32'h0050_0093, 32'hCAFE_F00D};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0,         32'h0050_0093, 32'h1111_2222};
    vt[5] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 32'h0,         32'hDEAD_BEEF, 32'h1111_2222};
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

    rst0 = 1'b0; rst3 = 1'b0; rst5 = 1'b0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    if0.core_req = 1'b1; if0.core_we = 1'b0; if0.core_address = '0; if0.core_wdata = '0;
    if0.loader_req = 1'b0; if0.loader_we = 1'b0; if0.loader_address = '0; if0.loader_wdata = '0;
    if3.core_req = 1'b0; if3.core_we = 1'b0; if3.core_address = '0; if3.core_wdata = '0;
    if3.loader_req = 1'b0; if3.loader_we = 1'b0; if3.loader_address = '0; if3.loader_wdata = '0;
    if5.core_req = 1'b0; if5.core_we = 1'b0; if5.core_address = '0; if5.core_wdata = '0;
    if5.loader_req = 1'b0; if5.loader_we = 1'b0; if5.loader_address = '0; if5.loader_wdata = '0;

    // Reset held with a core read pending: nothing may happen
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_acks", 64'({if0.core_ack, if0.loader_ack}), 64'd0);
      chk("rst_mem_rw", 64'({if0.mem_read, if0.mem_write}), 64'd0);
    end
    chk("rst_busy_owner", 64'({if0.busy, if0.owner}), 64'b01);
    chk("rst_mem_bus", {if0.mem_address, if0.mem_wdata}, 64'd0);
    chk("rst_rdata", {if0.core_rdata, if0.loader_rdata}, 64'd0);
    rst0 = 1'b1; rst3 = 1'b1; rst5 = 1'b1;
    wait_ack0(1'b0, 10, lat, n_rd, n_wr, n_oth);
    chk("rst_first_ack_latency", 64'(lat), 64'd2);
    if0.core_req = 1'b0;
    @(negedge clock);

    // Table of single accesses on the zero-wait instance
    for (int v = 0; v < 6; v++) begin
      if (vt[v].pre) preload(vt[v].addr[5:2], vt[v].pval);
      if (vt[v].ld) begin
        if0.loader_we = vt[v].we; if0.loader_address = vt[v].addr;
        if0.loader_wdata = vt[v].wdata; if0.loader_req = 1'b1;
      end else begin
        if0.core_we = vt[v].we; if0.core_address = vt[v].addr;
        if0.core_wdata = vt[v].wdata; if0.core_req = 1'b1;
      end
      wait_ack0(vt[v].ld, 10, lat, n_rd, n_wr, n_oth);
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_rw_cycles", v), {32'(n_rd), 32'(n_wr)},
          vt[v].we ? {32'd0, 32'd1} : {32'd1, 32'd0});
      chk($sformatf("vec%0d_other_ack", v), 64'(n_oth), 64'd0);
      chk($sformatf("vec%0d_core_rdata", v), 64'(if0.core_rdata), 64'(vt[v].exp_crd));
      chk($sformatf("vec%0d_loader_rdata", v), 64'(if0.loader_rdata), 64'(vt[v].exp_lrd));
      if0.core_req = 1'b0; if0.loader_req = 1'b0;
      @(negedge clock);
      chk($sformatf("vec%0d_ack_single", v), 64'({if0.core_ack, if0.loader_ack}), 64'd0);
    end

    // Both requesters tie, three reads each
    rst0 = 1'b0;
    @(negedge clock);
    rst0 = 1'b1;
    if0.core_we = 1'b0; if0.core_address = 32'h10; if0.core_req = 1'b1;
    if0.loader_we = 1'b0; if0.loader_address = 32'h14; if0.loader_req = 1'b1;
    got = 0; rem_c = 3; rem_l = 3;
    for (int n = 0; n < 80 && got < 6; n++) begin
      @(negedge clock);
      if (if0.core_ack || if0.loader_ack) begin
        chk($sformatf("arb%0d_port", got), 64'(if0.loader_ack), 64'(exp_own[got]));
        chk($sformatf("arb%0d_owner", got), 64'(if0.owner), 64'(exp_own[got]));
        got++;
      end
      if (if0.core_ack) begin if0.core_req = 1'b0; rem_c--; end
      else if (!if0.core_req && rem_c > 0) if0.core_req = 1'b1;
      if (if0.loader_ack) begin if0.loader_req = 1'b0; rem_l--; end
      else if (!if0.loader_req && rem_l > 0) if0.loader_req = 1'b1;
    end
    chk("arb_access_count", 64'(got), 64'd6);
    if0.core_req = 1'b0; if0.loader_req = 1'b0;
    @(negedge clock);

    // Random traffic against a transaction-level model
    for (int i = 0; i < 16; i++) begin
      mm[i] = $urandom;
      preload(4'(i), mm[i]);
    end
    rst0 = 1'b0;
    @(negedge clock);
    rst0 = 1'b1;
    m_have = 1'b0; m_owner = 1'b1; m_free = 0; m_gs = 0; m_ld = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rd = '0; e_crd = '0; e_lrd = '0;
    for (int k = 0; k < 400; k++) begin
      if (if0.core_ack) if0.core_req = 1'b0;
      else if (!if0.core_req && $urandom_range(0, 2) == 0) begin
        if0.core_we = 1'($urandom_range(0, 1));
        if0.core_address = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        if0.core_wdata = $urandom; if0.core_req = 1'b1;
      end
      if (if0.loader_ack) if0.loader_req = 1'b0;
      else if (!if0.loader_req && $urandom_range(0, 2) == 0) begin
        if0.loader_we = 1'($urandom_range(0, 1));
        if0.loader_address = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        if0.loader_wdata = $urandom; if0.loader_req = 1'b1;
      end
      // Each access: grant edge k, memory strobes k..k+W, ack at k+W+1, next grant k+W+3
      if (k >= m_free && (if0.core_req || if0.loader_req)) begin
        if (if0.core_req && if0.loader_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          m_ld = !m_owner;
`else
          m_ld = 1'b0;
`endif
        end else m_ld = if0.loader_req;
        m_owner = m_ld;
        m_we    = m_ld ? if0.loader_we : if0.core_we;
        m_addr  = m_ld ? if0.loader_address : if0.core_address;
        m_wdata = m_ld ? if0.loader_wdata : if0.core_wdata;
        if (m_we) mm[m_addr[5:2]] = m_wdata;
        else m_rd = mm[m_addr[5:2]];
        m_have = 1'b1; m_gs = k; m_free = k + W0 + 3;
      end
      in_busy = m_have && k >= m_gs && k <= m_gs + W0;
      in_resp = m_have && k == m_gs + W0 + 1;
      if (in_resp && !m_we) begin
        if (m_ld) e_lrd = m_rd;
        else e_crd = m_rd;
      end
      e_ctl = {in_resp && !m_ld, in_resp && m_ld, in_busy && !m_we, in_busy && m_we,
               in_busy || in_resp, m_owner};
      e_bus = in_busy ? {m_addr, m_wdata} : 64'd0;
      @(negedge clock);
      chk($sformatf("rnd%0d_ctl", k), 64'({if0.core_ack, if0.loader_ack, if0.mem_read,
          if0.mem_write, if0.busy, if0.owner}), 64'(e_ctl));
      chk($sformatf("rnd%0d_mem_bus", k), {if0.mem_address, if0.mem_wdata}, e_bus);
      chk($sformatf("rnd%0d_core_rdata", k), 64'(if0.core_rdata), 64'(e_crd));
      chk($sformatf("rnd%0d_loader_rdata", k), 64'(if0.loader_rdata), 64'(e_lrd));
    end
    if0.core_req = 1'b0; if0.loader_req = 1'b0;

    // Loader write through WAIT_CYCLES=3
    @(negedge clock);
    if3.loader_we = 1'b1; if3.loader_address = 32'h1001_0000;
    if3.loader_wdata = 32'hDEAD_BEEF; if3.loader_req = 1'b1;
    lat = -1; n_wr = 0; bad = 0; n_oth = 0;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      @(negedge clock);
      if (if3.mem_write) begin
        n_wr++;
        if (if3.mem_address != 32'h1001_0000 || if3.mem_wdata != 32'hDEAD_BEEF) bad++;
      end
      if (if3.mem_read || if3.core_ack) n_oth++;
      if (if3.loader_ack) lat = n;
    end
    if3.loader_req = 1'b0;
    chk("w3_ack_latency", 64'(lat), 64'd5);
    chk("w3_write_cycles", 64'(n_wr), 64'd4);
    chk("w3_write_bus", 64'(bad), 64'd0);
    chk("w3_stray_activity", 64'(n_oth), 64'd0);
    chk("w3_rdata_held", {if3.core_rdata, if3.loader_rdata}, 64'd0);

    // Reset in the middle of a WAIT_CYCLES=5 read
    @(negedge clock);
    if5.core_we = 1'b0; if5.core_address = 32'h40; if5.core_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("w5_read_in_busy", 64'(if5.mem_read), 64'd1);
    #2 rst5 = 1'b0;
    #1;
    chk("w5_read_async_drop", 64'({if5.mem_read, if5.busy}), 64'd0);
    if5.core_req = 1'b0;
    n_oth = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      if (if5.core_ack || if5.loader_ack) n_oth++;
    end
    rst5 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      if (if5.core_ack || if5.loader_ack) n_oth++;
    end
    chk("w5_no_ack", 64'(n_oth), 64'd0);
    chk("w5_idle_owner", 64'({if5.busy, if5.owner, if5.mem_read}), 64'b010);
    chk("w5_rdata_untouched", 64'(if5.core_rdata), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single unified instruction/data Memory port between two requesters: the multicycle core (port "core") and the program loader/debug port (port "loader").
- Sequences each access through a fixed-latency FSM and returns read data with a one-cycle acknowledge pulse.
- Sits between the multicycle datapath's address/data muxes and the Memory instance. The core treats a missing ack as a stall.

Parameters:
- WAIT_CYCLES, 0, extra cycles mem_read/mem_write are held beyond the first; allowed range 0..15.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- core_req  input  1  core requests an access; held until core_ack is seen.
- core_we  input  1  1 = write, 0 = read; sampled with core_req.
- core_address  input  ADDR_WIDTH  core access address.
- core_wdata  input  DATA_WIDTH  core write data.
- core_ack  output  1  one-cycle completion pulse to core.
- core_rdata  output  DATA_WIDTH  read data for core; valid while core_ack is high.
- loader_req  input  1  loader requests an access.
- loader_we  input  1  loader write enable.
- loader_address  input  ADDR_WIDTH  loader address.
- loader_wdata  input  DATA_WIDTH  loader write data.
- loader_ack  output  1  one-cycle completion pulse to loader.
- loader_rdata  output  DATA_WIDTH  read data for loader.
- mem_address  output  ADDR_WIDTH  to Memory iAddress.
- mem_wdata  output  DATA_WIDTH  to Memory iData.
- mem_write  output  1  to Memory write.
- mem_read  output  1  to Memory read.
- mem_rdata  input  DATA_WIDTH  from Memory oData.
- busy  output  1  high in BUSY or RESP.
- owner  output  1  current or last grant owner: 0 = core, 1 = loader.

Behaviour:
- One clock domain. reset_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - all acks, mem_read, mem_write and busy = 0.
  - mem_address, mem_wdata, core_rdata and loader_rdata = 0.
  - owner = 1, so the core wins the first tie.
  - wait counter = 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick the winner, latch its we/address/wdata into internal regs, set owner, load counter = WAIT_CYCLES, go to BUSY.
  - Arbitration is registered. No memory signal is driven in IDLE.
- BUSY:
  - Drive mem_address/mem_wdata from the latched regs. Drive mem_read = !we and mem_write = we.
  - Counter > 0: decrement and stay.
  - Counter == 0: on a read, capture mem_rdata into the owner's rdata register (the other rdata register holds). Go to RESP.
  - BUSY lasts exactly WAIT_CYCLES+1 cycles. Request inputs are ignored in BUSY.
- RESP:
  - Pulse the owner's ack for exactly one cycle. mem_read/mem_write = 0. Go to IDLE.
  - Writes leave both rdata registers unchanged.
- Latency: request seen in IDLE in cycle N → ack high in cycle N+WAIT_CYCLES+2. With WAIT_CYCLES=0, one access occupies 3 cycles.
- Requester rule:
  - Drop req on the edge that samples ack.
  - A req still high in the following IDLE cycle is a new request.
  - Address/data need only be valid in the cycle req is first sampled in IDLE.
- Simultaneous requests in IDLE: resolved by the arbitration policy (see Optional Feature). The loser keeps req high and is served on the next IDLE.
- owner holds its value through IDLE until the next grant.
- Reset mid-access: asynchronous return to IDLE. mem_read/mem_write drop immediately, no ack is issued, and the access is lost; the requester re-issues it after reset.
- No combinational path from any req input to any output.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a tie, grant the requester that is not the current owner (alternating service). A lone requester always wins.
- Undefined: fixed priority, core always wins ties. The loader can starve while the core issues back-to-back requests; this is acceptable because the loader runs only while the core is halted.

Test Plan:
- Reset with core_req=1 and core_we=0 held high throughout → no ack and mem_read=0 during reset. After release, first core_ack arrives 2 cycles after the IDLE sample (WAIT_CYCLES=0).
- Core read of address 0x00400000 while Memory returns 0x00500093 → mem_read high for 1 cycle, core_ack pulses once with core_rdata=0x00500093, loader_rdata stays 0.
- Loader write of 0xDEADBEEF to 0x10010000 with WAIT_CYCLES=3 → mem_write high for exactly 4 cycles with mem_address=0x10010000 and mem_wdata=0xDEADBEEF; loader_ack 5 cycles after the request.
- core_req and loader_req asserted together in the same cycle and re-asserted for three accesses each:
  - Without ARB_ROUND_ROBIN_EN: owner sequence 0,0,0,1,1,1.
  - With ARB_ROUND_ROBIN_EN: owner sequence 0,1,0,1,0,1.
- reset_n pulled low during BUSY with WAIT_CYCLES=5 → mem_read drops asynchronously, no ack pulses, state is IDLE and owner=1 after release.
- Core write followed by a loader read → core_rdata keeps its prior value (0x00500093) and only loader_rdata updates.
